// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, word type and controller states for the SHA-256 message schedule
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int SCHED_DEPTH = 16;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
endpackage

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: SHA-256 small sigma function, SEL=0 gives s0, SEL=1 gives s1
//   x_i  input word
//   y_o  rotr(x,R1) ^ rotr(x,R2) ^ shr(x,SH)
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter bit SEL = 1'b0
) (
  input  word_t x_i,
  output word_t y_o
);
  localparam int R1 = SEL ? 17 : 7;
  localparam int R2 = SEL ? 19 : 18;
  localparam int SH = SEL ? 10 : 3;
  assign y_o = ((x_i >> R1) | (x_i << (WORD_W - R1)))
             ^ ((x_i >> R2) | (x_i << (WORD_W - R2)))
             ^ (x_i >> SH);
endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: loads one 16-word block, then streams W[0..NUM_ROUNDS-1] with an in-place 16-entry schedule buffer
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begins loading a block (IDLE only)
//   in_valid/in_ready     word input handshake, in_word big-endian W[0] first
//   out_valid/out_ready   schedule word output handshake, out_word = W[out_idx]
//   busy                  high in LOAD or RUN
//   done                  one-cycle pulse after the last output handshake
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        busy,
  output logic        done
);
  localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] idx_q, idx_d;
  word_t mem_q [SCHED_DEPTH];
  word_t mem_d [SCHED_DEPTH];
  word_t sig0, sig1, w_exp, w_cur;
  logic [3:0] i;
  assign i = idx_q[3:0];
  // 4-bit index arithmetic gives the mod-16 circular offsets; t-15 == t+1 mod 16
  sha256_small_sigma #(.SEL(1'b0)) u_s0 (.x_i(mem_q[i + 4'd1]), .y_o(sig0));
  sha256_small_sigma #(.SEL(1'b1)) u_s1 (.x_i(mem_q[i - 4'd2]), .y_o(sig1));
  assign w_exp = sig1 + mem_q[i - 4'd7] + sig0 + mem_q[i];
  assign w_cur = (idx_q[5:4] == 2'b00) ? mem_q[i] : w_exp;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    mem_d = mem_q;
    unique case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: if (in_valid) begin
        mem_d[cnt_q] = in_word;
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd15) ? RUN : LOAD;
      end
      RUN: if (out_ready) begin
        if (idx_q[5:4] != 2'b00) mem_d[i] = w_cur;
        idx_d = (idx_q == LAST) ? 6'd0 : idx_q + 6'd1;
        state_d = (idx_q == LAST) ? DONE : RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      mem_q <= mem_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign out_valid = state_q == RUN;
  assign busy = in_ready | out_valid;
  assign done = state_q == DONE;
  assign out_word = out_valid ? w_cur : '0;
  assign out_idx = idx_q;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: directed checks of the SHA-256 message schedule against known vectors and a reference schedule
module tb_sha256_msg_sched;
  import sha256_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_word = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_word;
  logic [5:0] out_idx;
  logic busy;
  logic done;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  word_t blk [16];
  word_t ref_w [64];
  word_t got [64];

  sha256_msg_sched #(.NUM_ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref;
    word_t s0, s1;
    for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
      s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
      ref_w[t] = ref_w[t-16] + s0 + ref_w[t-7] + s1;
    end
  endtask

  task automatic set_abc;
    for (int k = 0; k < 16; k++) blk[k] = '0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_word"}, out_word, 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // A junk word is offered on the start cycle; IDLE must not take it
  task automatic load_block(input bit gaps, input bit poke_start);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_word = 32'hDEADBEEF;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b0;
      start = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_word = blk[k];
      start = poke_start && k == 5;
      chk("load_in_ready", 32'(in_ready), 32'd1);
      chk("load_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic run_block(input bit stall, input bit poke_start, input int stop_at);
    int t = 0;
    int guard = 0;
    while (t < 64 && guard < 2000) begin
      guard++;
      chk("run_valid", 32'(out_valid), 32'd1);
      chk("run_idx", 32'(out_idx), 32'(t));
      chk("run_word", out_word, ref_w[t]);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      got[t] = out_word;
      if (t == stop_at) return;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke_start && t == 20;
      if (out_ready) t++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start = 1'b0;
    chk("run_guard", 32'(t), 32'd64);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_out_valid", 32'(out_valid), 32'd0);
    // cycle index counted with the 16th-accept cycle as cycle 0
    if (!stall) chk("done_latency", 32'(cyc - acc_cyc + 1), 32'd65);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("no_queued_start", 32'(in_ready), 32'd0);
    chk("single_done", 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    set_abc();
    build_ref();
    load_block(1'b0, 1'b0);
    run_block(1'b0, 1'b0, -1);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_w18", got[18], 32'h7DA86405);
    chk("abc_w63", got[63], 32'h12B1EDEB);

    for (int k = 0; k < 16; k++) blk[k] = 32'hFFFFFFFF;
    build_ref();
    load_block(1'b0, 1'b0);
    run_block(1'b0, 1'b0, -1);
    chk("ones_w16", got[16], 32'h203FFFFC);

    set_abc();
    build_ref();
    load_block(1'b1, 1'b1);
    run_block(1'b1, 1'b1, -1);
    chk("stall_w63", got[63], 32'h12B1EDEB);

    load_block(1'b0, 1'b0);
    run_block(1'b0, 1'b0, 30);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    load_block(1'b0, 1'b0);
    run_block(1'b0, 1'b0, -1);
    chk("reload_w18", got[18], 32'h7DA86405);
    chk("reload_w63", got[63], 32'h12B1EDEB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
